// File: rtl/qoa_frame_parser.sv
// qoa_frame_parser: QOA byte-stream header checker, LMS state burst writer and residual slice emitter
// Parameters:
//   MAX_FSAMPLES  largest accepted samples-per-frame value
// Ports:
//   sys_clk, sys_rst_n                       clock, synchronous active-low reset
//   data_rdy, spi_in                         one-cycle byte strobe and stream byte (no backpressure)
//   lms_wr, lms_idx, lms_value               8-word LMS burst: idx 0-3 history, 4-7 weights
//   res_valid, res_ready                     residual handshake
//   res_sf, res_code, res_last               scalefactor, residual code, last residual of frame
//   frame_start, error, overflow             frame accepted pulse, sticky parse error, sticky overrun
// Build option: QOA_MAGIC_CHECK_EN compares the "qoaf" file magic; undefined skips it.
module qoa_frame_parser #(
    parameter int MAX_FSAMPLES = 5120
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        data_rdy,
    input  logic [7:0]  spi_in,
    output logic        lms_wr,
    output logic [2:0]  lms_idx,
    output logic [15:0] lms_value,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_sf,
    output logic [2:0]  res_code,
    output logic        res_last,
    output logic        frame_start,
    output logic        error,
    output logic        overflow
);
    typedef enum logic [2:0] {FILE_HDR, FRAME_HDR, LMS, SLICE, ERROR} state_t;
    state_t        state_q, state_d;
    logic [3:0]    bcnt_q;
    logic [7:0]    chan_q;
    logic [15:0]   fs_q;
    logic [15:0]   left_q;
    logic [127:0]  shadow_q;
    logic          arm_q;
    logic          burst_q;
    logic [2:0]    bidx_q;
    logic [63:0]   buf_q [2];
    logic [4:0]    cnt_q [2];
    logic [1:0]    full_q;
    logic [1:0]    last_q;
    logic [1:0]    hold_q;
    logic          wr_q;
    logic          rd_q;
    logic          drop_q;
    logic [4:0]    ridx_q;
    logic          frame_start_q;
    logic          error_q;
    logic          overflow_q;
    logic          magic_bad;
    logic          hdr_bad;
    logic          drop_now;
    logic          slice_end;
    logic          accept;
    logic          rd_done;
    logic          hold_new;
    logic [63:0]   rbuf;
`ifdef QOA_MAGIC_CHECK_EN
    localparam logic [3:0][7:0] MAGIC = {8'h71, 8'h6F, 8'h61, 8'h66};
    assign magic_bad = data_rdy && state_q == FILE_HDR && bcnt_q < 4'd4 &&
                       spi_in != MAGIC[2'd3 - bcnt_q[1:0]];
`else
    assign magic_bad = 1'b0;
`endif
    assign hdr_bad   = chan_q != 8'd1 || fs_q == 16'd0 || fs_q > 16'(MAX_FSAMPLES);
    // a slice is dropped as a whole if its first byte finds no free buffer
    assign drop_now  = (bcnt_q == 4'd0) ? full_q[wr_q] : drop_q;
    assign slice_end = data_rdy && state_q == SLICE && bcnt_q == 4'd7;
    assign rbuf      = buf_q[rd_q];
    assign accept    = res_valid && res_ready;
    assign rd_done   = accept && ridx_q == cnt_q[rd_q] - 5'd1;
    // slices of a frame whose LMS burst is still owed must wait behind that burst
    assign hold_new  = arm_q || (burst_q && bidx_q != 3'd7);
    always_comb begin
        state_d = state_q;
        if (data_rdy) begin
            case (state_q)
                FILE_HDR:  state_d = magic_bad ? ERROR : (bcnt_q == 4'd7 ? FRAME_HDR : FILE_HDR);
                FRAME_HDR: state_d = bcnt_q != 4'd7 ? FRAME_HDR : (hdr_bad ? ERROR : LMS);
                LMS:       state_d = bcnt_q == 4'd15 ? SLICE : LMS;
                SLICE:     state_d = (bcnt_q == 4'd7 && left_q <= 16'd20) ? FRAME_HDR : SLICE;
                default:   state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= FILE_HDR;
            bcnt_q        <= '0;
            chan_q        <= '0;
            fs_q          <= '0;
            left_q        <= '0;
            shadow_q      <= '0;
            arm_q         <= 1'b0;
            burst_q       <= 1'b0;
            bidx_q        <= '0;
            buf_q         <= '{default: '0};
            cnt_q         <= '{default: '0};
            full_q        <= '0;
            last_q        <= '0;
            hold_q        <= '0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            drop_q        <= 1'b0;
            ridx_q        <= '0;
            frame_start_q <= 1'b0;
            error_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_start_q <= 1'b0;
            if (state_d == ERROR) error_q <= 1'b1;
            if (data_rdy && state_q != ERROR)
                bcnt_q <= (state_d != state_q || slice_end) ? 4'd0 : bcnt_q + 4'd1;
            if (data_rdy && state_q == FRAME_HDR) begin
                if (bcnt_q == 4'd0) chan_q <= spi_in;
                if (bcnt_q == 4'd4 || bcnt_q == 4'd5) fs_q <= {fs_q[7:0], spi_in};
                if (bcnt_q == 4'd7 && !hdr_bad) begin
                    frame_start_q <= 1'b1;
                    left_q        <= fs_q;
                end
            end
            if (burst_q) begin
                bidx_q <= bidx_q + 3'd1;
                if (bidx_q == 3'd7) begin
                    burst_q <= 1'b0;
                    hold_q  <= '0;
                end
            end else if (arm_q && (!full_q[rd_q] || hold_q[rd_q])) begin
                burst_q <= 1'b1;
                arm_q   <= 1'b0;
                bidx_q  <= '0;
            end
            if (data_rdy && state_q == LMS) begin
                shadow_q <= {shadow_q[119:0], spi_in};
                if (bcnt_q == 4'd15) arm_q <= 1'b1;
            end
            if (accept) begin
                ridx_q <= rd_done ? 5'd0 : ridx_q + 5'd1;
                if (rd_done) begin
                    full_q[rd_q] <= 1'b0;
                    rd_q         <= ~rd_q;
                end
            end
            if (data_rdy && state_q == SLICE) begin
                drop_q <= drop_now;
                if (bcnt_q == 4'd0 && drop_now) overflow_q <= 1'b1;
                if (!drop_now) buf_q[wr_q] <= {buf_q[wr_q][55:0], spi_in};
                if (bcnt_q == 4'd7) begin
                    left_q <= left_q > 16'd20 ? left_q - 16'd20 : 16'd0;
                    if (!drop_now) begin
                        full_q[wr_q] <= 1'b1;
                        cnt_q[wr_q]  <= left_q > 16'd20 ? 5'd20 : left_q[4:0];
                        last_q[wr_q] <= left_q <= 16'd20;
                        hold_q[wr_q] <= hold_new;
                        wr_q         <= ~wr_q;
                    end
                end
            end
            if (state_q == ERROR) begin
                full_q  <= '0;
                arm_q   <= 1'b0;
                burst_q <= 1'b0;
            end
        end
    end
    assign lms_wr      = burst_q && state_q != ERROR;
    assign lms_idx     = lms_wr ? bidx_q : 3'd0;
    assign lms_value   = lms_wr ? 16'(shadow_q >> (7'd112 - {bidx_q, 4'b0000})) : 16'd0;
    assign res_valid   = full_q[rd_q] && !hold_q[rd_q] && !burst_q && state_q != ERROR;
    assign res_sf      = res_valid ? rbuf[63:60] : 4'd0;
    assign res_code    = res_valid ? 3'(rbuf >> (6'd57 - 6'(3 * ridx_q))) : 3'd0;
    assign res_last    = res_valid && last_q[rd_q] && ridx_q == cnt_q[rd_q] - 5'd1;
    assign frame_start = frame_start_q;
    assign error       = error_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_qoa_frame_parser.sv
// tb_qoa_frame_parser: directed byte streams with a queue scoreboard and a negedge monitor
module tb_qoa_frame_parser;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        data_rdy = 1'b0;
    logic [7:0]  spi_in = 8'h00;
    logic        res_ready = 1'b0;
    logic        lms_wr;
    logic [2:0]  lms_idx;
    logic [15:0] lms_value;
    logic        res_valid;
    logic [3:0]  res_sf;
    logic [2:0]  res_code;
    logic        res_last;
    logic        frame_start;
    logic        error;
    logic        overflow;
    int pass_cnt = 0;
    int tot_cnt = 0;
    int ev_cnt = 0;
    int fs_cnt = 0;
    int e0;
    int f0;
    logic [18:0] lms_q [$];
    logic [7:0]  res_q [$];
    logic [18:0] le;
    logic [7:0]  re;
    logic [63:0] v;
    localparam logic [0:7][15:0] W1 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'hE000, 16'h4000};
    localparam logic [0:7][15:0] W2 = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    localparam logic [0:7][15:0] W3 = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0100, 16'h0ABC, 16'hF00D, 16'h1234, 16'hCAFE};
    localparam logic [63:0] S1 = 64'h3000000000000001;
    localparam logic [63:0] S2 = 64'hAFAC600000000000;
    localparam logic [63:0] S3 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [31:0] QOAF = 32'h716F6166;
    localparam logic [31:0] QOAX = 32'h716F6178;

    always #5 sys_clk = ~sys_clk;

    qoa_frame_parser dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data_rdy(data_rdy), .spi_in(spi_in),
        .lms_wr(lms_wr), .lms_idx(lms_idx), .lms_value(lms_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_sf(res_sf), .res_code(res_code),
        .res_last(res_last), .frame_start(frame_start), .error(error), .overflow(overflow)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (frame_start) fs_cnt++;
            if (lms_wr) begin
                ev_cnt++;
                if (lms_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL lms_wr unexpected: idx %0d value %0h, none expected", lms_idx, lms_value);
                end else begin
                    le = lms_q.pop_front();
                    check("lms {idx,value}", {lms_idx, lms_value}, le);
                end
            end
            if (res_valid && res_ready) begin
                ev_cnt++;
                if (res_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL residual unexpected: sf %0d code %0d last %0d, none expected", res_sf, res_code, res_last);
                end else begin
                    re = res_q.pop_front();
                    check("residual {sf,code,last}", {res_sf, res_code, res_last}, re);
                end
            end
        end
    end

    task automatic send_byte(logic [7:0] b);
        data_rdy = 1'b1;
        spi_in   = b;
        @(posedge sys_clk); #1;
        data_rdy = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic send_bytes(logic [63:0] x, int n);
        for (int i = 0; i < n; i++) send_byte(x[63-8*i -: 8]);
    endtask

    function automatic logic [63:0] fh(logic [7:0] ch, logic [15:0] fs);
        return {ch, 24'h00AC44, fs, 16'h0040};
    endfunction

    task automatic send_file(logic [31:0] m);
        send_bytes({m, 32'h00000014}, 8);
    endtask

    task automatic send_lms(logic [0:7][15:0] w);
        for (int i = 0; i < 8; i++) begin
            send_byte(w[i][15:8]);
            send_byte(w[i][7:0]);
        end
    endtask

    task automatic push_lms(logic [0:7][15:0] w);
        for (int i = 0; i < 8; i++) lms_q.push_back({3'(i), w[i]});
    endtask

    task automatic push_slice(logic [63:0] s, int n, bit last);
        logic [2:0] c;
        for (int i = 0; i < n; i++) begin
            c = s[59-3*i -: 3];
            res_q.push_back({s[63:60], c, last && i == n - 1});
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((lms_q.size() != 0 || res_q.size() != 0) && n < 3000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check({name, " pending expectations"}, lms_q.size() + res_q.size(), 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        data_rdy  = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        lms_q.delete();
        res_q.delete();
        sys_rst_n = 1'b1;
    endtask

    task automatic check_zero(string tag);
        check({tag, " lms_wr"}, lms_wr, 0);
        check({tag, " lms_idx"}, lms_idx, 0);
        check({tag, " lms_value"}, lms_value, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_sf"}, res_sf, 0);
        check({tag, " res_code"}, res_code, 0);
        check({tag, " res_last"}, res_last, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " error"}, error, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    task automatic basic_stream(string name);
        push_lms(W1);
        push_slice(S1, 20, 1'b1);
        send_file(QOAF);
        send_bytes(fh(8'd1, 16'd20), 8);
        send_lms(W1);
        send_bytes(S1, 8);
        wait_drain(name);
        check({name, " error"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_zero("reset");
        sys_rst_n = 1'b1;

        // frame 1: fsamples=20, one slice, timed commit check
        push_lms(W1);
        push_slice(S1, 20, 1'b1);
        send_file(QOAF);
        send_bytes(fh(8'd1, 16'd20), 8);
        check("frame_start after hdr1", fs_cnt, 1);
        send_lms(W1);
        send_bytes(S1, 7);
        check("res_valid before commit", res_valid, 0);
        v = S1;
        data_rdy = 1'b1;
        spi_in   = v[7:0];
        @(posedge sys_clk); #1;
        data_rdy = 1'b0;
        check("res_valid after commit", res_valid, 1);
        check("res_sf after commit", res_sf, 3);
        @(posedge sys_clk); #1;
        wait_drain("frame1");

        // frame 2: fsamples=25, second slice carries 5 residuals
        push_lms(W2);
        push_slice(S1, 20, 1'b0);
        push_slice(S2, 5, 1'b1);
        send_bytes(fh(8'd1, 16'd25), 8);
        check("frame_start after hdr2", fs_cnt, 2);
        send_lms(W2);
        send_bytes(S1, 8);
        send_bytes(S2, 8);
        wait_drain("frame2");

        // frame 3: stalled sink, third slice overruns
        res_ready = 1'b0;
        push_lms(W3);
        push_slice(S2, 20, 1'b0);
        push_slice(S1, 20, 1'b0);
        send_bytes(fh(8'd1, 16'd60), 8);
        check("frame_start after hdr3", fs_cnt, 3);
        send_lms(W3);
        send_bytes(S2, 8);
        send_bytes(S1, 8);
        check("overflow before third slice", overflow, 0);
        check("res_valid while stalled", res_valid, 1);
        send_bytes(S3, 8);
        check("overflow after third slice", overflow, 1);
        res_ready = 1'b1;
        wait_drain("frame3");
        check("error after frame3", error, 0);

        // channels=2
        do_reset();
        e0 = ev_cnt;
        send_file(QOAF);
        v = fh(8'd2, 16'd20);
        send_bytes(v, 7);
        check("ch2 error before 8th byte", error, 0);
        send_byte(v[7:0]);
        check("ch2 error after 8th byte", error, 1);
        send_lms(W1);
        send_bytes(S1, 8);
        check("ch2 no outputs", ev_cnt - e0, 0);
        check("ch2 res_valid", res_valid, 0);

        // fsamples above the limit
        do_reset();
        e0 = ev_cnt;
        send_file(QOAF);
        v = fh(8'd1, 16'd5121);
        send_bytes(v, 7);
        check("fs5121 error before 8th byte", error, 0);
        send_byte(v[7:0]);
        check("fs5121 error after 8th byte", error, 1);
        send_lms(W1);
        send_bytes(S1, 8);
        check("fs5121 no outputs", ev_cnt - e0, 0);

        // fsamples zero
        do_reset();
        e0 = ev_cnt;
        send_file(QOAF);
        send_bytes(fh(8'd1, 16'd0), 8);
        check("fs0 error", error, 1);

        // bad magic
        do_reset();
        e0 = ev_cnt;
        f0 = fs_cnt;
`ifdef QOA_MAGIC_CHECK_EN
        send_file(QOAX);
        check("qoax error", error, 1);
        send_bytes(fh(8'd1, 16'd20), 8);
        send_lms(W1);
        send_bytes(S1, 8);
        check("qoax no outputs", ev_cnt - e0, 0);
        check("qoax no frame_start", fs_cnt - f0, 0);
`else
        push_lms(W1);
        push_slice(S1, 20, 1'b1);
        send_file(QOAX);
        send_bytes(fh(8'd1, 16'd20), 8);
        check("qoax frame_start", fs_cnt - f0, 1);
        send_lms(W1);
        send_bytes(S1, 8);
        wait_drain("qoax");
        check("qoax error", error, 0);
`endif

        // reset mid-slice with a residual pending
        do_reset();
        res_ready = 1'b0;
        push_lms(W2);
        send_file(QOAF);
        send_bytes(fh(8'd1, 16'd40), 8);
        send_lms(W2);
        send_bytes(S2, 8);
        send_bytes(S1, 3);
        wait_drain("pre-reset burst");
        check("res_valid before reset", res_valid, 1);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check("midreset res_valid", res_valid, 0);
        check("midreset res_sf", res_sf, 0);
        check("midreset res_code", res_code, 0);
        check("midreset lms_wr", lms_wr, 0);
        check("midreset error", error, 0);
        check("midreset overflow", overflow, 0);
        do_reset();
        res_ready = 1'b1;
        basic_stream("after reset");
        check("after reset overflow", overflow, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/qoa_frame_parser.md
# qoa_frame_parser

Byte-level QOA stream parser between the SPI receive front end and the LMS/dequantiser stage inside the decoder. It consumes the synchronised byte stream (`data_rdy`/`spi_in`) and checks the file and frame headers. It captures per-frame LMS state and issues it as an 8-word write burst, and buffers 64-bit slices in a 2-entry ping-pong store. It then emits one residual per accepted handshake, tagged with its scalefactor and an end-of-frame marker. Mono streams only.

## Interface
Parameters:
- `MAX_FSAMPLES`, 5120: largest legal samples-per-frame value.

Ports:
- `sys_clk`  in  1  system clock; sole clock.
- `sys_rst_n`  in  1  reset; synchronous, active-low.
- `data_rdy`  in  1  one-cycle strobe, `spi_in` valid; no backpressure.
- `spi_in`  in  8  stream byte, file order.
- `lms_wr`  out  1  LMS state write strobe.
- `lms_idx`  out  3  0–3 history[0..3], 4–7 weights[0..3].
- `lms_value`  out  16  signed LMS word.
- `res_valid`  out  1  residual available.
- `res_ready`  in  1  downstream accepts residual.
- `res_sf`  out  4  scalefactor index of current slice.
- `res_code`  out  3  quantised residual code.
- `res_last`  out  1  last residual of frame.
- `frame_start`  out  1  one-cycle pulse when a frame header is accepted.
- `error`  out  1  sticky parse error.
- `overflow`  out  1  sticky slice-buffer overrun.

## Operation
- The reset value of every output is 0. The FSM enters `FILE_HDR`. Byte counters, slice buffers and LMS shadow are cleared.
- All fields are big-endian. Each state counts bytes only on `data_rdy`.
- `FILE_HDR`, 8 bytes:
  - Bytes 0–3 are magic `0x71 0x6F 0x61 0x66` ("qoaf"). Bytes 4–7 (total samples) are ignored.
  - Then `FRAME_HDR`. This state is visited once per reset.
- `FRAME_HDR`, 8 bytes:
  - Byte 0 is channels; it must be 1. Bytes 1–3 are samplerate (ignored). Bytes 4–5 are fsamples. Bytes 6–7 are fsize (ignored).
  - fsamples==0 or fsamples>`MAX_FSAMPLES` gives an error.
  - On the 8th byte: `frame_start` pulses, slices_left=ceil(fsamples/20), and the FSM goes to `LMS`.
- `LMS`, 16 bytes:
  - Bytes are shifted into a 128-bit shadow.
  - After the 16th byte the FSM goes to `SLICE` and the LMS burst is armed.
- LMS burst:
  - Starts when armed, both slice buffers are empty and no residual is pending.
  - Issues 8 consecutive cycles of `lms_wr`=1, with `lms_idx` 0..7 and `lms_value` taken from the shadow words in order.
  - Residual emission is held until the burst completes. Slice bytes keep buffering during the burst.
- `SLICE`, 8 bytes per slice:
  - Bytes are assembled MSB-first into the current write buffer.
  - On the 8th byte the slice is committed with count=min(20, samples_left) and last=(slices_left==1). slices_left is then decremented.
  - When slices_left reaches 0 the FSM goes to `FRAME_HDR`.
- Slice layout: sf=bits[63:60]; residual r_i=bits[59-3i:57-3i] for i=0..19. Trailing residuals beyond count are never emitted.
- Emitter:
  - Reads the oldest full buffer and presents r_0 first.
  - Advances on `res_valid&&res_ready`.
  - `res_last`=1 only on the final counted residual of a slice marked last.
  - The buffer is freed after its final residual is accepted.
- Overflow: if a slice's first byte arrives while both buffers are full, the whole slice is dropped and `overflow` is set. Parsing counts continue so framing stays aligned.
- Error:
  - Any header violation sets `error` and moves the FSM to `ERROR`.
  - In `ERROR` all bytes are ignored, pending buffers are discarded, and `res_valid`/`lms_wr` are 0.
  - Only reset exits `ERROR`.

## Timing
- Bytes are registered on the `data_rdy` cycle. The state or counter update is visible the next cycle.
- `data_rdy` strobes are at least 2 cycles apart. No input FIFO exists.
- Slice commit: `res_valid` rises 1 cycle after the 8th byte's `data_rdy`, provided the emitter is idle and no LMS burst is pending or active.
- Throughput: one residual per cycle while `res_ready`=1. `res_valid` and data stay stable until accepted.
- Buffer handoff: the next buffer's r_0 is presented the cycle after the previous slice's final accept (no bubble beyond 1 cycle).
- LMS burst: starts the cycle after the start condition holds. Duration is exactly 8 cycles.
- `sys_rst_n` low mid-operation: outputs are 0 on the next edge. A strobe concurrent with reset is discarded.

## Configuration
- `QOA_MAGIC_CHECK_EN` defined: the file-header magic is compared byte by byte, and a mismatch sets `error`.
- `QOA_MAGIC_CHECK_EN` undefined: all 8 file-header bytes are skipped without checking. The channel and fsamples checks remain.

## Test plan
- Valid header "qoaf", 1 channel, fsamples=20, LMS history {1,2,3,4}, weights {0,0,-8192,16384}, 1 slice `0x3000000000000001` → 8 `lms_wr` pulses idx 0..7 with those values; then 20 residuals, sf=3, r_0..r_18=0, r_19=1, `res_last` on r_19.
- fsamples=25 → 2 slices; second slice emits exactly 5 residuals, last with `res_last`=1; FSM returns to `FRAME_HDR`; next frame header gives `frame_start`.
- `res_ready` held 0 with 3 slices sent → third slice dropped, `overflow`=1; first two slices emit intact after `res_ready`=1.
- Magic "qoax" → `error`=1, no `lms_wr`/`res_valid` ever; with the macro undefined the same stream decodes normally.
- channels=2, or fsamples=5121 → `error`=1 after the 8th frame-header byte.
- Reset asserted mid-slice with `res_valid`=1 → all outputs 0 next cycle; a fresh full stream decodes correctly.
